// File: rtl/audio_i2s_tx.sv
// Left-justified I2S-style serializer for the WM8731 DAC port: one 16-bit sample
// repeated on both channels, with a once-per-frame next-sample request.
module audio_i2s_tx #(
    parameter int unsigned BCLK_DIV = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        INIT_FINISH,
    input  logic        mute,
    input  logic [15:0] sample_data,
    output logic        data_over,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned WORD_W = 16;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q,  state_d;
    logic [DIV_W-1:0]    div_q,    div_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [WORD_W-1:0]   word_q,   word_d;
    logic [WORD_W-1:0]   shift_q,  shift_d;
    logic                bclk_q,   bclk_d;
    logic                lrck_q,   lrck_d;
    logic                dat_q,    dat_d;
    logic                dov_q,    dov_d;

    logic [WORD_W-1:0]   fresh_word;
    logic [BIT_W-1:0]    bit_inc;

    // Word captured at frame start; mute forces silence for the whole frame.
    assign fresh_word = mute ? '0 : sample_data;
    assign bit_inc    = bit_q + BIT_W'(1);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        word_d  = word_q;
        shift_d = shift_q;
        bclk_d  = bclk_q;
        lrck_d  = lrck_q;
        dat_d   = dat_q;
        dov_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (INIT_FINISH) begin
                    state_d = RUN;
                    word_d  = fresh_word;
                    shift_d = fresh_word;
                    dat_d   = fresh_word[WORD_W-1];
                    div_d   = '0;
                    bit_d   = '0;
                    bclk_d  = 1'b0;
                    lrck_d  = 1'b0;
                end
            end
            RUN: begin
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // Data and channel only move on the BCLK falling edge.
                    if (bclk_q) begin
                        bit_d  = bit_inc;
                        lrck_d = bit_inc[BIT_W-1];
                        if (bit_inc == BIT_W'(0)) begin
                            word_d  = fresh_word;
                            shift_d = fresh_word;
                            dat_d   = fresh_word[WORD_W-1];
                        end else if (bit_inc == BIT_W'(16)) begin
                            shift_d = word_q;
                            dat_d   = word_q[WORD_W-1];
                            dov_d   = ~mute;
                        end else begin
                            shift_d = {shift_q[WORD_W-2:0], 1'b0};
                            dat_d   = shift_q[WORD_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            shift_q <= '0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            dov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            dov_q   <= dov_d;
        end
    end

    assign data_over   = dov_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;

endmodule
